// File: rtl/ysyx_23060096_seq_ctrl_if.sv
// rtl/ysyx_23060096_seq_ctrl_if.sv - shared instruction/data memory port between sequencer and bus
interface ysyx_23060096_seq_ctrl_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_wen,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_wen,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/ysyx_23060096_seq_ctrl.sv
// rtl/ysyx_23060096_seq_ctrl.sv - multi-cycle fetch/decode/mem/writeback sequencer with halt on ebreak or bus fault
module ysyx_23060096_seq_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060096_seq_ctrl_if.master      mem,
    input  logic                          dec_is_load,
    input  logic                          dec_is_store,
    input  logic                          dec_is_ebreak,
    input  logic [31:0]                   next_pc,
    input  logic [31:0]                   lsu_addr,
    input  logic [31:0]                   lsu_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   inst,
    output logic [31:0]                   load_data,
    output logic                          rf_wen_gate,
    output logic                          retire,
    output logic [63:0]                   instret,
    output logic                          halted,
    output logic                          bus_err
);

    typedef enum logic [2:0] {
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tmo_cnt;
    logic        mem_is_store;
    logic        timed_out;
    logic        halt_err;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic        wb_gate;
    logic        enter_req;
    logic        on_bus;

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_addr  = req_addr;
    assign mem.mem_req_wen   = req_wen;
    assign mem.mem_req_wdata = req_wdata;
    assign rf_wen_gate       = wb_gate;
    assign retire            = wb_gate;

    assign timed_out = (tmo_cnt == TIMEOUT);
    assign on_bus    = (state == S_FETCH_REQ) || (state == S_FETCH_WAIT) ||
                       (state == S_MEM_REQ)   || (state == S_MEM_WAIT);
    assign enter_req = ((state_nxt == S_FETCH_REQ) && (state != S_FETCH_REQ)) ||
                       ((state_nxt == S_MEM_REQ)   && (state != S_MEM_REQ));

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wen   = 1'b0;
        req_wdata = 32'h0;
        wb_gate   = 1'b0;
        halt_err  = 1'b0;
        case (state)
            S_FETCH_REQ: begin
                // A misaligned PC never reaches the bus.
                if (pc[1:0] != 2'b00) begin
                    state_nxt = S_HALT;
                    halt_err  = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    req_addr  = pc;
                    if (mem.mem_req_ready) begin
                        state_nxt = S_FETCH_WAIT;
                    end else if (timed_out) begin
                        state_nxt = S_HALT;
                        halt_err  = 1'b1;
                    end
                end
            end
            S_FETCH_WAIT: begin
                if (mem.mem_resp_valid) begin
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    state_nxt = S_HALT;
                    halt_err  = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_is_ebreak) begin
                    state_nxt = S_HALT;
                end else if (dec_is_load || dec_is_store) begin
                    state_nxt = S_MEM_REQ;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM_REQ: begin
                req_valid = 1'b1;
                req_addr  = lsu_addr;
                req_wen   = mem_is_store;
                req_wdata = lsu_wdata;
                if (mem.mem_req_ready) begin
                    state_nxt = S_MEM_WAIT;
                end else if (timed_out) begin
                    state_nxt = S_HALT;
                    halt_err  = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem.mem_resp_valid) begin
                    state_nxt = S_WB;
                end else if (timed_out) begin
                    state_nxt = S_HALT;
                    halt_err  = 1'b1;
                end
            end
            S_WB: begin
                wb_gate   = 1'b1;
                state_nxt = S_FETCH_REQ;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase
        // The register state is only reloaded at the edge, so mask side effects during the reset cycle.
        if (rst) begin
            req_valid = 1'b0;
            wb_gate   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH_REQ;
            pc           <= PC_RESET;
            inst         <= 32'h0000_0013;
            load_data    <= 32'h0;
            instret      <= 64'h0;
            halted       <= 1'b0;
            bus_err      <= 1'b0;
            tmo_cnt      <= 8'h0;
            mem_is_store <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt == S_HALT) && (state != S_HALT)) begin
                halted <= 1'b1;
                if (halt_err) begin
                    bus_err <= 1'b1;
                end
            end
            // One budget covers both the request and the wait phase of a transfer.
            if (enter_req) begin
                tmo_cnt <= 8'h0;
            end else if (on_bus && (state_nxt != S_HALT)) begin
                tmo_cnt <= tmo_cnt + 8'h1;
            end
            if ((state == S_FETCH_WAIT) && mem.mem_resp_valid) begin
                inst <= mem.mem_resp_data;
            end
            if (state == S_DECODE) begin
                mem_is_store <= dec_is_store;
            end
            if ((state == S_MEM_WAIT) && mem.mem_resp_valid && !mem_is_store) begin
                load_data <= mem.mem_resp_data;
            end
            if (state == S_WB) begin
                pc      <= next_pc;
                instret <= instret + 64'h1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_seq_ctrl.sv
// tb/tb_ysyx_23060096_seq_ctrl.sv - directed scoreboard bench for the multi-cycle sequencer
module tb_ysyx_23060096_seq_ctrl;

    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    localparam logic [31:0] I_ADDI   = 32'h0010_8093;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] I_LW     = 32'h0001_2083;
    localparam logic [31:0] I_SW     = 32'h0011_2023;
    localparam int STOP_NONE = 0;
    localparam int STOP_RET  = 1;
    localparam int STOP_HALT = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  rdy;
        logic [7:0]  rsp;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ret_t;

    logic        clk;
    logic        rst;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_is_ebreak;
    logic [31:0] next_pc;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] load_data;
    logic        rf_wen_gate;
    logic        retire;
    logic [63:0] instret;
    logic        halted;
    logic        bus_err;

    ysyx_23060096_seq_ctrl_if mem_if ();

    ysyx_23060096_seq_ctrl #(
        .PC_RESET (PC_RESET),
        .TIMEOUT  (8'd255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mem_if),
        .dec_is_load   (dec_is_load),
        .dec_is_store  (dec_is_store),
        .dec_is_ebreak (dec_is_ebreak),
        .next_pc       (next_pc),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .pc            (pc),
        .inst          (inst),
        .load_data     (load_data),
        .rf_wen_gate   (rf_wen_gate),
        .retire        (retire),
        .instret       (instret),
        .halted        (halted),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert;
    int          n_fail;
    int          cyc;
    int          req_wait;
    int          rsp_cnt;
    int          rsp_lat;
    bit          rsp_pend;
    bit          stray;
    bit          saw_retire;
    logic [31:0] rsp_data;
    logic [31:0] pc_model;
    req_t        exp_q[$];
    ret_t        ret_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory model and score DUT outputs at the falling edge.
    task automatic step();
        req_t h;
        ret_t r;
        @(negedge clk);
        cyc++;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = 32'h0;
        mem_if.mem_req_ready  = 1'b0;
        if (rsp_pend) begin
            rsp_cnt++;
            if (rsp_cnt == rsp_lat) begin
                mem_if.mem_resp_valid = 1'b1;
                mem_if.mem_resp_data  = rsp_data;
                rsp_pend = 1'b0;
            end
        end
        if (mem_if.mem_req_valid) begin
            if (exp_q.size() == 0) begin
                check("req_unexpected", mem_if.mem_req_valid, 0);
            end else begin
                h = exp_q[0];
                check("req_addr", mem_if.mem_req_addr, h.addr);
                check("req_wen", mem_if.mem_req_wen, h.wen);
                if (h.wen) check("req_wdata", mem_if.mem_req_wdata, h.wdata);
                if (req_wait >= int'(h.rdy)) begin
                    mem_if.mem_req_ready = 1'b1;
                    rsp_data = h.rdata;
                    rsp_lat  = int'(h.rsp);
                    rsp_pend = (h.rsp != 8'd0);
                    rsp_cnt  = 0;
                    req_wait = 0;
                    void'(exp_q.pop_front());
                    if (stray) begin
                        mem_if.mem_resp_valid = 1'b1;
                        mem_if.mem_resp_data  = 32'hffff_ffff;
                        stray = 1'b0;
                    end
                end else begin
                    req_wait++;
                end
            end
        end
        check("gate_vs_retire", rf_wen_gate, retire);
        if (retire) begin
            saw_retire = 1'b1;
            if (ret_q.size() == 0) begin
                check("retire_unexpected", retire, 0);
            end else begin
                r = ret_q.pop_front();
                check("retire_pc", pc, r.pc);
                check("retire_inst", inst, r.inst);
            end
        end
    endtask

    task automatic run(input int budget, input int mode, output int n);
        n = 0;
        saw_retire = 1'b0;
        while (n < budget) begin
            step();
            n++;
            if ((mode == STOP_RET && saw_retire) || (mode == STOP_HALT && halted)) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] iw, input logic ld, input logic st, input logic eb,
                         input logic [31:0] npc, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int f_rsp, input int m_rdy, input int m_rsp);
        req_t q;
        ret_t r;
        dec_is_load   = ld;
        dec_is_store  = st;
        dec_is_ebreak = eb;
        next_pc       = npc;
        lsu_addr      = addr;
        lsu_wdata     = wd;
        q.addr = pc_model; q.wen = 1'b0; q.wdata = 32'h0; q.rdata = iw;
        q.rdy = 8'd0; q.rsp = 8'(f_rsp);
        exp_q.push_back(q);
        if (ld || st) begin
            q.addr = addr; q.wen = st; q.wdata = wd; q.rdata = rd;
            q.rdy = 8'(m_rdy); q.rsp = 8'(m_rsp);
            exp_q.push_back(q);
        end
        if (!eb) begin
            r.pc = pc_model; r.inst = iw;
            ret_q.push_back(r);
            pc_model = npc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = 32'h0;
        exp_q.delete();
        ret_q.delete();
        rsp_pend = 1'b0;
        req_wait = 0;
        stray    = 1'b0;
        pc_model = PC_RESET;
        @(posedge clk);
        #1;
        check("rst_req_valid", mem_if.mem_req_valid, 0);
        check("rst_gate", rf_wen_gate, 0);
        check("rst_retire", retire, 0);
        check("rst_pc", pc, PC_RESET);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_load_data", load_data, 0);
        check("rst_instret", instret, 0);
        check("rst_halted", halted, 0);
        check("rst_bus_err", bus_err, 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int n;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0;
        next_pc = 32'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_data = 32'h0;

        // Three addi then ebreak on zero-wait memory.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            issue(I_ADDI, 0, 0, 0, pc_model + 32'd4, 32'h0, 32'h0, 32'h0, 1, 0, 0);
            run(20, STOP_RET, n);
            check("alu_retire_cycle", cyc, 4 * k);
        end
        issue(I_EBREAK, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run(20, STOP_HALT, n);
        check("ebreak_halt_cycle", cyc, 16);
        check("ebreak_halted", halted, 1);
        check("ebreak_bus_err", bus_err, 0);
        check("ebreak_instret", instret, 3);
        run(5, STOP_NONE, n);
        check("ebreak_pc_frozen", pc, PC_RESET + 32'd12);

        // Zero-wait load, then a store with a slow ready and a late ack.
        do_reset();
        issue(I_LW, 1, 0, 0, PC_RESET + 32'd4, 32'h8000_0100, 32'h0, 32'hDEAD_BEEF, 1, 0, 1);
        run(30, STOP_RET, n);
        check("load_cycles", n, 6);
        check("load_data", load_data, 32'hDEAD_BEEF);
        check("load_pc_next", pc, PC_RESET + 32'd4);
        check("load_instret", instret, 1);
        issue(I_SW, 0, 1, 0, PC_RESET + 32'd8, 32'h8000_0200, 32'h1234_5678, 32'h0, 1, 3, 2);
        run(30, STOP_RET, n);
        check("store_cycles", n, 10);
        check("store_instret", instret, 2);
        check("store_load_data_kept", load_data, 32'hDEAD_BEEF);

        // Reset while a load waits for its response, then a fetch with a stray same-cycle response.
        issue(I_LW, 1, 0, 0, PC_RESET + 32'd12, 32'h8000_0300, 32'h0, 32'h0BAD_F00D, 1, 0, 8);
        run(5, STOP_NONE, n);
        check("midload_no_retire", instret, 2);
        do_reset();
        stray = 1'b1;
        issue(I_ADDI, 0, 0, 0, PC_RESET + 32'd4, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run(20, STOP_RET, n);
        check("after_rst_cycles", n, 4);
        check("after_rst_instret", instret, 1);

        // Misaligned next_pc halts at the following fetch without a request.
        issue(I_ADDI, 0, 0, 0, 32'h8000_0002, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run(20, STOP_RET, n);
        check("misalign_alu_cycles", n, 4);
        run(10, STOP_HALT, n);
        check("misalign_halt_cycles", n, 2);
        check("misalign_halted", halted, 1);
        check("misalign_bus_err", bus_err, 1);
        run(4, STOP_NONE, n);
        check("misalign_pc", pc, 32'h8000_0002);

        // Fetch response never arrives: the wait budget runs out.
        do_reset();
        issue(I_ADDI, 0, 0, 0, PC_RESET + 32'd4, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run(300, STOP_HALT, n);
        check("timeout_halt_cycles", n, 257);
        check("timeout_halted", halted, 1);
        check("timeout_bus_err", bus_err, 1);
        run(4, STOP_NONE, n);
        check("timeout_instret", instret, 0);
        check("timeout_pc", pc, PC_RESET);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
